control_unit: RTL
=================

# control_unit

Multi-cycle instruction sequencer for the RISC16 datapath. It fetches 16-bit instructions from memory, decodes them, and drives the ALU opcode, register-file selects and write enable, and memory strobes. It latches the ALU carry/negative/zero outputs into architectural flags and resolves conditional branches against them. It is the issuing end of the ALU operation interface: the ALU is a pure combinational consumer of `alu_op`, and this block is its only producer.

## Interface
- `PC_RESET`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_rdata` in 16: memory read data (instruction or load data).
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `alu_y` in 16: ALU result.
- `alu_c`, `alu_n`, `alu_z` in 1 each: ALU flag outputs.
- `mem_addr` out 16: memory address.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe. Write data is the register-file S port, outside this block.
- `alu_op` out 4: ALU operation code.
- `r_sel` out 3: register-file R read select.
- `s_sel` out 3: register-file S read select.
- `w_sel` out 3: register-file write select.
- `reg_we` out 1: register-file write enable.
- `wb_sel` out 1: write-back source. 0 = `alu_y`, 1 = `mem_rdata`.
- `flags` out 3: latched {C,N,Z}.
- `pc` out 16: current program counter.
- `halted` out 1: high in HALT state.

## Operation
- **Instruction fields:** op=ir[15:12], rd=ir[11:9], rs=ir[8:6], rt=ir[5:3], cond=ir[11:9], off=ir[8:0] (signed).
- **ALU opcodes:** op 0x0–0xC use `alu_op`=op; ALU ops 0xD–0xF are never issued.
- **Instruction classes:**
  - op 0x0–0xC: ALU op, rd ← f(rs, rt); flags updated.
  - op 0xD: LD, rd ← mem[rs].
  - op 0xE: ST, mem[rs] ← rt.
  - op 0xF: branch/halt.
  - LD, ST and branch leave flags unchanged.
- **States:** FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT.
- **FETCH:** `mem_addr`=pc, `mem_rd`=1. On `mem_ready`: ir←`mem_rdata`, pc←pc+1 (mod 2^16), go to DECODE. Otherwise hold.
- **DECODE (1 cycle):** `r_sel`=rs, `s_sel`=rt, `alu_op` as in EXEC.
  - op≤0xC → EXEC.
  - op 0xD → MEM_RD.
  - op 0xE → MEM_WR.
  - op 0xF → EXEC.
- **EXEC, op≤0xC:**
  - Outputs: `alu_op`=op, `r_sel`=rs, `s_sel`=rt, `w_sel`=rd, `wb_sel`=0, `reg_we`=1.
  - At the edge, flags←{`alu_c`,`alu_n`,`alu_z`}. Next state FETCH.
- **EXEC, op=0xF:**
  - Take the branch when cond=000 (always), 001 C, 010 N, 011 Z, 100 !C, 101 !N, or 110 !Z.
  - Taken: pc←pc+sext(off), mod 2^16. The pc here is already incremented. Next state FETCH.
  - cond=111: next state HALT, pc unchanged.
- **MEM_RD:**
  - Outputs: `alu_op`=0001 (pass R), `r_sel`=rs, `mem_addr`=`alu_y`, `mem_rd`=1.
  - On `mem_ready`: `reg_we`=1, `w_sel`=rd, `wb_sel`=1, then FETCH.
- **MEM_WR:**
  - Outputs: `alu_op`=0001, `r_sel`=rs, `s_sel`=rt, `mem_addr`=`alu_y`, `mem_wr`=1.
  - On `mem_ready`, go to FETCH.
- **HALT:** all strobes 0, `halted`=1. Only reset exits.
- **Output encoding:** all outputs are decoded from state and ir. Any output not listed for a state is 0; `alu_op` defaults to 0000.

## Timing
- **Reset (asynchronous):**
  - State=FETCH, pc=`PC_RESET`, ir=0, flags=000.
  - Hence `mem_rd`=1 and `mem_addr`=`PC_RESET` while reset is held and immediately after it.
  - `mem_wr`=0, `reg_we`=0, `halted`=0.
- **Minimum latency with `mem_ready` tied high:** ALU op, LD, ST and branch each take 3 cycles. Each wait cycle adds 1.
- **Stall behaviour:** strobes and `mem_addr` stay stable for every cycle of a stall.
- **Write strobe:** `reg_we` is asserted in exactly one cycle per ALU op or LD.
- **Reset mid-operation:** aborts the instruction immediately. No write completes after reset asserts, and flags clear.
- **Flag forwarding:** a flag update in EXEC is visible to a branch in the very next instruction.
- **PC wrap:** 0xFFFF wraps to 0x0000.
- **Branch range:** offset spans −256..+255.

## Test plan
- **Reset:** assert reset mid-MEM_WR → `mem_wr` drops asynchronously; `pc`=0x0000, `flags`=000, `mem_rd`=1, `mem_addr`=0x0000.
- **ADD:** instr 0x2250 (ADD r1,r1,r2) with `alu_y`=0x0000, `alu_z`=1, `mem_ready`=1 → `reg_we` high for 1 cycle in cycle 3 with `w_sel`=1, `alu_op`=0010; then `flags`=001 and `pc`=1.
- **LD with wait states:** LD with `mem_ready` low for 2 MEM_RD cycles → `mem_rd` and `mem_addr`=`alu_y` stable for 3 cycles; one `reg_we` with `wb_sel`=1; total 5 cycles.
- **Conditional branch:** after a flag update with Z=1, JZ off=−2 at pc=0x0010 (pc incremented to 0x0011) → pc=0x000F. Same with Z=0 → pc=0x0011.
- **PC wrap:** fetch at pc=0xFFFF → pc=0x0000. Branch +255 from 0xFF80 → 0x007F.
- **HALT:** HALT instr 0xFE00 → `halted`=1, no strobes for 20 cycles; reset returns to FETCH.

Source files
------------

// File: rtl/control_unit.sv
// RISC16 multi-cycle sequencer: fetch, decode, execute and memory phases,
// with latched ALU flags feeding conditional branches.
module control_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] alu_y,
  input  logic        alu_c,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [3:0]  alu_op,
  output logic [2:0]  r_sel,
  output logic [2:0]  s_sel,
  output logic [2:0]  w_sel,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [2:0]  flags,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_LD  = 4'hD;
  localparam logic [3:0] OP_ST  = 4'hE;
  localparam logic [3:0] OP_BR  = 4'hF;
  localparam logic [3:0] ALU_PASS_R = 4'h1;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  flags_q, flags_d;

  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, cond;
  logic [15:0] off_sx;
  logic        is_alu;
  logic        br_take;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs     = ir_q[8:6];
  assign rt     = ir_q[5:3];
  assign cond   = ir_q[11:9];
  assign off_sx = {{7{ir_q[8]}}, ir_q[8:0]};
  assign is_alu = (op <= 4'hC);

  // flags_q is {C,N,Z}
  always_comb begin
    br_take = 1'b0;
    case (cond)
      3'd0: br_take = 1'b1;
      3'd1: br_take = flags_q[2];
      3'd2: br_take = flags_q[1];
      3'd3: br_take = flags_q[0];
      3'd4: br_take = ~flags_q[2];
      3'd5: br_take = ~flags_q[1];
      3'd6: br_take = ~flags_q[0];
      default: br_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= 16'h0000;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    mem_addr = 16'h0000;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = 4'h0;
    r_sel    = 3'd0;
    s_sel    = 3'd0;
    w_sel    = 3'd0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        mem_rd   = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        r_sel  = rs;
        s_sel  = rt;
        alu_op = is_alu ? op : 4'h0;
        unique case (1'b1)
          is_alu:       state_d = S_EXEC;
          (op == OP_LD): state_d = S_MEM_RD;
          (op == OP_ST): state_d = S_MEM_WR;
          (op == OP_BR): state_d = S_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          alu_op  = op;
          r_sel   = rs;
          s_sel   = rt;
          w_sel   = rd;
          reg_we  = 1'b1;
          flags_d = {alu_c, alu_n, alu_z};
        end else if (op == OP_BR) begin
          if (cond == 3'b111) begin
            state_d = S_HALT;
          end else if (br_take) begin
            pc_d = pc_q + off_sx;
          end
        end
      end
      S_MEM_RD: begin
        alu_op   = ALU_PASS_R;
        r_sel    = rs;
        mem_addr = alu_y;
        mem_rd   = 1'b1;
        if (mem_ready) begin
          reg_we  = 1'b1;
          w_sel   = rd;
          wb_sel  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WR: begin
        alu_op   = ALU_PASS_R;
        r_sel    = rs;
        s_sel    = rt;
        mem_addr = alu_y;
        mem_wr   = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign flags = flags_q;
  assign pc    = pc_q;

endmodule
